// File: rtl/hq_issue_ctrl.sv
// hq_issue_ctrl
// Issues one block of eight stored channel coefficients to a downstream
// |h|^2 accumulator and captures the block energy it returns.
//
// Optional feature macro: HQ_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles without a result and pulses err
//   undefined : WAIT holds until Dh_result_valid; err is tied low
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_addr      coefficient-buffer write (dropped while busy)
//   wr_real, wr_im      signed Q-format coefficient to write
//   start               request to issue one 8-sample block (IDLE only)
//   Dh_en               per-sample valid to the accumulator
//   out_real, out_im    sample accompanying Dh_en, zero otherwise
//   Dh_in               accumulated energy from the accumulator
//   Dh_result_valid     accumulator result strobe
//   dh_energy           captured block energy
//   busy, done, err     status; done/err are single-cycle pulses
module hq_issue_ctrl #(
  parameter int Q       = 8,
  parameter int N       = 16,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [N-1:0] wr_real,
  input  logic [N-1:0] wr_im,
  input  logic         start,
  output logic         Dh_en,
  output logic [N-1:0] out_real,
  output logic [N-1:0] out_im,
  input  logic [N-1:0] Dh_in,
  input  logic         Dh_result_valid,
  output logic [N-1:0] dh_energy,
  output logic         busy,
  output logic         done,
  output logic         err
);

  if (Q >= N || TIMEOUT < 1) begin : g_param_check
    $error("hq_issue_ctrl: need Q < N and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t       state;
  logic [2:0]   idx;
  logic [N-1:0] buf_re [8];
  logic [N-1:0] buf_im [8];

  assign busy = (state != IDLE);

  // A write in the start cycle lands at the same edge that enters ISSUE,
  // and entry 0 is read one cycle later, so it is always seen by the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else if (wr_en && state == IDLE) begin
      buf_re[wr_addr] <= wr_real;
      buf_im[wr_addr] <= wr_im;
    end
  end

`ifdef HQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Dh_en lags the ISSUE state by one cycle, so the 8th sample is still on
  // the bus during the first WAIT cycle; a result strobe is only honoured
  // once Dh_en has dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      Dh_en     <= 1'b0;
      out_real  <= '0;
      out_im    <= '0;
      dh_energy <= '0;
      done      <= 1'b0;
`ifdef HQ_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      Dh_en    <= 1'b0;
      out_real <= '0;
      out_im   <= '0;
`ifdef HQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // done high means the block just finished; a start here is dropped
          if (start && !done) begin
            state <= ISSUE;
            idx   <= '0;
          end
        end
        ISSUE: begin
          Dh_en    <= 1'b1;
          out_real <= buf_re[idx];
          out_im   <= buf_im[idx];
          idx      <= idx + 3'd1;
`ifdef HQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (idx == 3'd7) state <= WAIT;
        end
        WAIT: begin
          if (Dh_result_valid && !Dh_en) begin
            dh_energy <= Dh_in;
            done      <= 1'b1;
            state     <= IDLE;
          end
`ifdef HQ_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hq_issue_ctrl.sv
// Self-checking bench for hq_issue_ctrl: directed sequence with randomized
// coefficients, checked against a shadow coefficient table and an energy
// formula sum((re^2 + im^2) >>> Q) over the eight entries.
module tb_hq_issue_ctrl;
  localparam int Q       = 8;
  localparam int N       = 16;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [N-1:0] wr_real, wr_im;
  logic         start;
  logic         Dh_en;
  logic [N-1:0] out_real, out_im;
  logic [N-1:0] Dh_in;
  logic         Dh_result_valid;
  logic [N-1:0] dh_energy;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] sh_re [8];
  logic [N-1:0] sh_im [8];
  logic [N-1:0] last_energy;

  always #5 clk = ~clk;

  hq_issue_ctrl #(.Q(Q), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_real(wr_real), .wr_im(wr_im), .start(start), .Dh_en(Dh_en),
    .out_real(out_real), .out_im(out_im), .Dh_in(Dh_in),
    .Dh_result_valid(Dh_result_valid), .dh_energy(dh_energy),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int energy(input logic [N-1:0] re, input logic [N-1:0] im);
    int r, i;
    r = int'($signed(re));
    i = int'($signed(im));
    return (r * r + i * i) >>> Q;
  endfunction

  function automatic logic [N-1:0] rnd_coef();
    int v;
    v = int'($urandom_range(0, 512)) - 256;
    return v[N-1:0];
  endfunction

  // Called at a negedge with the DUT idle.
  task automatic write_entry(input int a, input logic [N-1:0] re, input logic [N-1:0] im);
    logic [2:0] a3;
    a3 = a[2:0];
    wr_en = 1'b1; wr_addr = a3; wr_real = re; wr_im = im;
    sh_re[a3] = re; sh_im[a3] = im;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // mode 0 normal, 1 write+bogus valid during ISSUE, 2 extra starts,
  // 3 write in start cycle, 4 accumulator never answers
  task automatic run_block(input int mode);
    logic [N-1:0] er [8];
    logic [N-1:0] ei [8];
    int k, t, acc, sum, extra;
    logic [N-1:0] exp_e;
    bit sent, fin, tmo;
    if (mode == 3) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_real = rnd_coef(); wr_im = rnd_coef();
      sh_re[0] = wr_real; sh_im[0] = wr_im;
    end
    start = 1'b1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      er[i] = sh_re[i]; ei[i] = sh_im[i];
      sum += energy(sh_re[i], sh_im[i]);
    end
    exp_e = sum[N-1:0];
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    k = 0; t = -1; acc = 0; sent = 0; fin = 0; tmo = 0;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      if (tmo) begin
        chk("err_pulse_width", {31'b0, err}, 32'd0);
        chk("timeout_no_done", {31'b0, done}, 32'd0);
        fin = 1;
      end else if (sent) begin
        Dh_result_valid = 1'b0;
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("dh_energy", 32'(dh_energy), 32'(exp_e));
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("err_on_done", {31'b0, err}, 32'd0);
        last_energy = exp_e;
        if (mode == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        fin = 1;
      end else begin
        Dh_result_valid = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        chk("no_early_done", {31'b0, done}, 32'd0);
        if (Dh_en) begin
          if (k < 8) begin
            chk($sformatf("out_real[%0d]", k), 32'(out_real), 32'(er[k]));
            chk($sformatf("out_im[%0d]", k), 32'(out_im), 32'(ei[k]));
          end
          acc += energy(out_real, out_im);
          k++;
          if (k == 8) t = 0;
          if (k > 8) chk("dh_en_overrun", k, 32'd8);
          if (mode == 1 && k == 2) begin
            wr_en = 1'b1; wr_addr = 3'd3; wr_real = 16'h7FFF; wr_im = 16'h7FFF;
          end
          if (mode == 1 && k == 3) begin
            Dh_result_valid = 1'b1; Dh_in = 16'hBEEF;
          end
          if (mode == 2 && k == 4) start = 1'b1;
        end else if (out_real !== '0 || out_im !== '0) begin
          chk("out_zero_when_idle", {out_real, out_im}, 32'd0);
        end
        if (t >= 0) begin
          if (mode == 4) begin
`ifdef HQ_TIMEOUT_EN
            if (t == 15) begin
              chk("wait_busy", {31'b0, busy}, 32'd1);
              chk("err_early", {31'b0, err}, 32'd0);
            end
            if (t == 16) begin
              chk("timeout_err", {31'b0, err}, 32'd1);
              chk("timeout_busy", {31'b0, busy}, 32'd0);
              chk("timeout_energy", 32'(dh_energy), 32'(last_energy));
              tmo = 1;
            end
`else
            if (t == 20) begin
              chk("wait_err_tied", {31'b0, err}, 32'd0);
              chk("wait_busy_hold", {31'b0, busy}, 32'd1);
              Dh_result_valid = 1'b1; Dh_in = acc[N-1:0]; sent = 1;
            end
`endif
          end else if (!Dh_en) begin
            Dh_result_valid = 1'b1; Dh_in = acc[N-1:0]; sent = 1;
          end
          t++;
        end
        @(negedge clk);
      end
    end
    Dh_result_valid = 1'b0;
    if (!fin) chk("block_timeout", 32'd0, 32'd1);
    chk("dh_en_count", k, 32'd8);
    if (mode == 2) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (Dh_en) extra++;
        @(negedge clk);
      end
      chk("no_second_block", extra, 32'd0);
      chk("idle_after_starts", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    int cnt, dcnt;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_im = '0;
    start = 1'b0; Dh_in = '0; Dh_result_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin sh_re[i] = '0; sh_im[i] = '0; end
    last_energy = '0;
    repeat (2) @(negedge clk);
    chk("rst_dh_en", {31'b0, Dh_en}, 32'd0);
    chk("rst_out", {out_real, out_im}, 32'd0);
    chk("rst_energy", 32'(dh_energy), 32'd0);
    chk("rst_status", {29'b0, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_block(0);

    for (int i = 0; i < 8; i++) write_entry(i, 16'h0100, 16'h0000);
    run_block(0);
    chk("unit_energy", 32'(dh_energy), 32'h0800);

    for (int i = 0; i < 8; i++) write_entry(i, 16'h0080, 16'h0080);
    run_block(0);
    chk("half_energy", 32'(dh_energy), 32'h0400);

    Dh_result_valid = 1'b1; Dh_in = 16'h1234;
    @(negedge clk);
    Dh_result_valid = 1'b0;
    chk("idle_valid_energy", 32'(dh_energy), 32'(last_energy));
    chk("idle_valid_done", {31'b0, done}, 32'd0);

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) write_entry(i, rnd_coef(), rnd_coef());
      run_block(0);
    end

    run_block(1);
    run_block(0);
    run_block(2);
    run_block(3);

    for (int i = 0; i < 8; i++) write_entry(i, rnd_coef(), rnd_coef());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 5; c++) begin
      if (Dh_en) cnt++;
      if (cnt < 5) @(negedge clk);
    end
    chk("reached_issue5", cnt, 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_dh_en", {31'b0, Dh_en}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_energy", 32'(dh_energy), 32'd0);
    for (int i = 0; i < 8; i++) begin sh_re[i] = '0; sh_im[i] = '0; end
    last_energy = '0;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || err || Dh_en) dcnt++;
      @(negedge clk);
    end
    chk("midrst_quiet", dcnt, 32'd0);
    for (int i = 0; i < 8; i++) write_entry(i, rnd_coef(), rnd_coef());
    run_block(0);

    run_block(4);
`ifndef HQ_TIMEOUT_EN
    chk("no_err_default", {31'b0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
